// File: rtl/flasher_state_counter.sv
// Sequential half of the lamp flasher: state/count registers, tick
// prescaler, flick synchronizer with pending latch, thermometer lamps.
module flasher_state_counter #(
  parameter int TICK_DIV    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int NUM_LAMPS   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flk_in,
  input  logic [2:0]           nxt_st,
  output logic [2:0]           cur_st,
  output logic [4:0]           count,
  output logic                 flk,
  output logic                 tick,
  output logic [NUM_LAMPS-1:0] led
);

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_0_15 = 3'd1,
    ST_15_5 = 3'd2,
    ST_5_10 = 3'd3,
    ST_10_0 = 3'd4,
    ST_0_5  = 3'd5,
    ST_5_0  = 3'd6,
    ST_BAD  = 3'd7
  } st_t;

  localparam logic [15:0] PMAX = 16'(TICK_DIV - 1);
  localparam logic [4:0]  CMAX = 5'(NUM_LAMPS);

  st_t                  r_st;
  st_t                  w_nst;
  logic [4:0]           r_cnt;
  logic [4:0]           w_ncnt;
  logic [15:0]          r_presc;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 r_flk_d;
  logic                 r_pend;
  logic [NUM_LAMPS-1:0] r_led;
  logic [NUM_LAMPS-1:0] w_therm;
  logic                 w_tick;
  logic                 w_flk_s;

  // Gated by rst_n so TICK_DIV=1 stays quiet while in reset.
  assign w_tick  = rst_n & (r_presc == PMAX);
  assign w_flk_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_nst  = st_t'(nxt_st);
    w_ncnt = r_cnt;
    case (w_nst)
      ST_0_15, ST_5_10, ST_0_5:
        w_ncnt = (r_cnt >= CMAX) ? CMAX : r_cnt + 5'd1;
      ST_15_5, ST_10_0, ST_5_0:
        w_ncnt = (r_cnt == 5'd0) ? 5'd0 : r_cnt - 5'd1;
      ST_BAD: begin
        w_nst  = ST_INIT;
        w_ncnt = 5'd0;
      end
      default: w_ncnt = 5'd0;
    endcase
  end

  always_comb begin
    w_therm = '0;
    for (int i = 0; i < NUM_LAMPS; i++) begin
      w_therm[i] = (5'(i) < r_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_sync  <= '0;
      r_flk_d <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_presc <= (r_presc == PMAX) ? '0 : r_presc + 16'd1;
      r_sync  <= {r_sync[SYNC_STAGES-2:0], flk_in};
      r_flk_d <= w_flk_s;
      // An edge landing on a tick is consumed directly via flk_s.
      if (w_tick) begin
        r_pend <= 1'b0;
      end else if (w_flk_s && !r_flk_d) begin
        r_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= ST_INIT;
      r_cnt <= '0;
      r_led <= '0;
    end else begin
      if (w_tick) begin
        r_st  <= w_nst;
        r_cnt <= w_ncnt;
      end
      r_led <= w_therm;
    end
  end

  assign cur_st = r_st;
  assign count  = r_cnt;
  assign flk    = w_flk_s | r_pend;
  assign tick   = w_tick;
  assign led    = r_led;

endmodule

// File: tb/tb_flasher_state_counter.sv
// Bench for flasher_state_counter: two instances (TICK_DIV 1 and 4)
// run against a per-cycle behavioural model of the lamp sequence.
module tb_flasher_state_counter;

  localparam int S  = 2;
  localparam int NL = 16;
  localparam int HN = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  nxt  [2];
  logic [2:0]  cst  [2];
  logic [4:0]  cnt  [2];
  logic        flkin[2];
  logic        flko [2];
  logic        tk   [2];
  logic [15:0] led  [2];

  always #5 clk = ~clk;

  flasher_state_counter #(
    .TICK_DIV(1), .SYNC_STAGES(S), .NUM_LAMPS(NL)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flk_in(flkin[0]),
    .nxt_st(nxt[0]), .cur_st(cst[0]), .count(cnt[0]),
    .flk(flko[0]), .tick(tk[0]), .led(led[0])
  );

  flasher_state_counter #(
    .TICK_DIV(4), .SYNC_STAGES(S), .NUM_LAMPS(NL)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flk_in(flkin[1]),
    .nxt_st(nxt[1]), .cur_st(cst[1]), .count(cnt[1]),
    .flk(flko[1]), .tick(tk[1]), .led(led[1])
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          div[2] = '{1, 4};
  int          ms[2], mc[2], kk[2], tkc[2];
  logic [15:0] mled[2];
  bit          pend[2], fprev[2];
  bit          fh[2][HN];
  int          fcnt[2];
  bit          force_en[2];
  logic [2:0]  force_v[2];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in for next_state_generator, reproducing the lamp sequence.
  function automatic int gen(int st, int c, bit f);
    case (st)
      0: return f ? 1 : 0;
      1: return (c >= 16) ? 2 : 1;
      2: return (c <= 5) ? 3 : 2;
      3: return (c >= 11) ? 4 : 3;
      4: return (f && c == 5) ? 3 : ((c == 0) ? 5 : 4);
      5: return (c >= 6) ? 6 : 5;
      6: return (c == 0) ? 0 : 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] therm(int c);
    logic [31:0] v;
    v = (32'd1 << c) - 32'd1;
    return v[15:0];
  endfunction

  function automatic bit m_flks(int j);
    return (kk[j] >= S) ? fh[j][(kk[j] - S) % HN] : 1'b0;
  endfunction

  function automatic bit m_tick(int j);
    return (kk[j] % div[j]) == div[j] - 1;
  endfunction

  task automatic step(input int j, input int nv, input bit fs);
    bit t;
    t = m_tick(j);
    mled[j] = therm(mc[j]);
    if (t) begin
      pend[j] = 1'b0;
      tkc[j]++;
      if (nv inside {1, 3, 5})      mc[j] = (mc[j] >= 16) ? 16 : mc[j] + 1;
      else if (nv inside {2, 4, 6}) mc[j] = (mc[j] <= 0) ? 0 : mc[j] - 1;
      else                          mc[j] = 0;
      ms[j] = (nv == 7) ? 0 : nv;
    end else if (fs && !fprev[j]) begin
      pend[j] = 1'b1;
    end
    fprev[j] = fs;
    fh[j][kk[j] % HN] = flkin[j];
    kk[j]++;
  endtask

  task automatic do_cycle();
    for (int j = 0; j < 2; j++) begin
      bit fs, f;
      int nv;
      fs = m_flks(j);
      f  = fs | pend[j];
      check($sformatf("cur_st%0d", j), cst[j], ms[j]);
      check($sformatf("count%0d", j), cnt[j], mc[j]);
      check($sformatf("tick%0d", j), tk[j], m_tick(j));
      check($sformatf("flk%0d", j), flko[j], f);
      check($sformatf("led%0d", j), led[j], mled[j]);
      flkin[j] = (fcnt[j] > 0);
      if (fcnt[j] > 0) fcnt[j]--;
      nv = force_en[j] ? int'(force_v[j]) : gen(ms[j], mc[j], f);
      nxt[j] = 3'(nv);
      step(j, nv, fs);
    end
  endtask

  task automatic adv();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("rst_st%0d", j), cst[j], 0);
      check($sformatf("rst_cnt%0d", j), cnt[j], 0);
      check($sformatf("rst_led%0d", j), led[j], 0);
      check($sformatf("rst_tick%0d", j), tk[j], 0);
      check($sformatf("rst_flk%0d", j), flko[j], 0);
      flkin[j] = 1'b0;
      fcnt[j] = 0;
      force_en[j] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      ms[j] = 0; mc[j] = 0; kk[j] = 0; tkc[j] = 0;
      mled[j] = '0; pend[j] = 1'b0; fprev[j] = 1'b0;
    end
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int pk, n, nft;
    for (int j = 0; j < 2; j++) begin
      nxt[j] = 3'd0;
      flkin[j] = 1'b0;
      force_v[j] = 3'd0;
    end
    do_reset();

    // Full sequence after a 3-clk flick.
    fcnt[0] = 3;
    fcnt[1] = 3;
    pk = 0;
    repeat (300) begin
      if (int'(cnt[0]) > pk) pk = int'(cnt[0]);
      do_cycle();
      adv();
    end
    check("peak16", pk, 16);
    check("endA_st", cst[0], 0);
    check("endA_cnt", cnt[0], 0);
    check("endA_led", led[0], 0);

    // Short pulse mid-prescale on the slow instance.
    n = 0;
    while (kk[1] % 4 != 2 && n < 8) begin
      do_cycle();
      adv();
      n++;
    end
    check("t4_align", kk[1] % 4, 2);
    fcnt[1] = 1;
    nft = 0;
    repeat (8) begin
      if (tk[1] && flko[1]) nft++;
      do_cycle();
      adv();
    end
    check("t4_flkticks", nft, 1);
    check("t4_st", cst[1], 1);
    check("t4_cnt", cnt[1], 1);

    // Flick during 10_TO_0 at count 5 bounces back to 5_TO_10.
    fcnt[0] = 1;
    n = 0;
    while (!(ms[0] == 4 && mc[0] == 7) && n < 300) begin
      do_cycle();
      adv();
      n++;
    end
    check("t3_wait", n < 300, 1);
    fcnt[0] = 1;
    repeat (3) begin
      do_cycle();
      adv();
    end
    check("t3_st", cst[0], 3);
    check("t3_cnt", cnt[0], 6);

    // Saturation and illegal state on the fast instance.
    tkc[0] = 0;
    force_en[0] = 1'b1;
    repeat (50) begin
      force_v[0] = (tkc[0] < 20) ? 3'd1 :
                   (tkc[0] == 20) ? 3'd5 :
                   (tkc[0] == 21) ? 3'd7 :
                   (tkc[0] < 45) ? 3'd6 : 3'd0;
      if (tkc[0] == 20) check("sat_hi", cnt[0], 16);
      if (tkc[0] == 21) check("sat_hold", cnt[0], 16);
      if (tkc[0] == 22) check("bad_st", cst[0], 0);
      if (tkc[0] == 22) check("bad_cnt", cnt[0], 0);
      if (tkc[0] == 45) check("sat_lo", cnt[0], 0);
      do_cycle();
      adv();
    end
    force_en[0] = 1'b0;

    // Random flicks and occasional forced next states.
    repeat (1500) begin
      for (int j = 0; j < 2; j++) begin
        if (fcnt[j] == 0 && $urandom_range(0, 19) == 0)
          fcnt[j] = int'($urandom_range(1, 6));
        force_en[j] = ($urandom_range(0, 29) == 0);
        force_v[j] = 3'($urandom_range(0, 7));
      end
      do_cycle();
      adv();
    end
    force_en[0] = 1'b0;
    force_en[1] = 1'b0;

    // Async reset at count 9 in 0_TO_15, then a clean restart.
    do_reset();
    fcnt[0] = 3;
    fcnt[1] = 3;
    n = 0;
    while (!(ms[0] == 1 && mc[0] == 9) && n < 200) begin
      do_cycle();
      adv();
      n++;
    end
    check("t6_wait", n < 200, 1);
    check("t6_pre_cnt", cnt[0], 9);
    do_reset();
    fcnt[0] = 3;
    fcnt[1] = 3;
    repeat (300) begin
      do_cycle();
      adv();
    end
    check("endD_st", cst[1], 0);
    check("endD_cnt", cnt[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
